// File: rtl/bus_xbar_arb.sv
// Shared-bus crossbar: N_SRC sources deliver words to N_DST destinations through
// a single holding register, with round-robin source arbitration.
module bus_xbar_arb #(
    parameter  int WIDTH = 8,
    parameter  int N_SRC = 4,
    parameter  int N_DST = 4,
    localparam int DW    = $clog2(N_DST),
    localparam int PW    = $clog2(N_SRC)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_SRC-1:0]       src_valid,
    input  logic [N_SRC*WIDTH-1:0] src_data,
    input  logic [N_SRC*DW-1:0]    src_dst,
    output logic [N_SRC-1:0]       src_ready,
    output logic [N_DST-1:0]       dst_valid,
    output logic [N_DST*WIDTH-1:0] dst_data,
    input  logic [N_DST-1:0]       dst_ready,
    output logic                   err_drop,
    output logic [15:0]            xfer_count
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bus_data_q, bus_data_d;
    logic [DW-1:0]    bus_dst_q, bus_dst_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [15:0]      xfer_count_q, xfer_count_d;

    logic             full, in_range, tgt_ready, take, drop, free, accept;
    logic             gnt_vld;
    logic [PW-1:0]    gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic [DW-1:0]    gnt_dst;

    // First requester found walking cyclically upward from start; MSB flags a hit.
    function automatic logic [PW:0] rr_pick(input logic [N_SRC-1:0] req,
                                            input logic [PW-1:0]    start);
        logic [PW:0]   res;
        logic [PW-1:0] idx;
        res = '0;
        idx = start;
        for (int i = 0; i < N_SRC; i++) begin
            if (!res[PW] && req[idx]) res = {1'b1, idx};
            idx = (idx == PW'(N_SRC - 1)) ? '0 : idx + 1'b1;
        end
        return res;
    endfunction

    always_comb begin
        full      = (state_q == FULL);
        in_range  = 1'b0;
        tgt_ready = 1'b0;
        for (int j = 0; j < N_DST; j++) begin
            if (bus_dst_q == DW'(j)) begin
                in_range  = 1'b1;
                tgt_ready = dst_ready[j];
            end
        end
        take = full & in_range & tgt_ready;
        drop = full & ~in_range;
        // A discarded word frees the register in the same cycle, like a take.
        free = ~full | take | drop;
        {gnt_vld, gnt_idx} = rr_pick(src_valid, ptr_q);
        accept   = gnt_vld & free & rst_n;
        gnt_data = '0;
        gnt_dst  = '0;
        src_ready = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (gnt_idx == PW'(i)) begin
                gnt_data = src_data[i*WIDTH +: WIDTH];
                gnt_dst  = src_dst[i*DW +: DW];
            end
            src_ready[i] = accept & (gnt_idx == PW'(i));
        end
    end

    always_comb begin
        state_d      = state_q;
        bus_data_d   = bus_data_q;
        bus_dst_d    = bus_dst_q;
        ptr_d        = ptr_q;
        xfer_count_d = xfer_count_q + {15'd0, take};
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (!accept && (take || drop)) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (accept) begin
            bus_data_d = gnt_data;
            bus_dst_d  = gnt_dst;
            ptr_d      = (gnt_idx == PW'(N_SRC - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            bus_data_q   <= '0;
            bus_dst_q    <= '0;
            ptr_q        <= '0;
            xfer_count_q <= '0;
        end else begin
            state_q      <= state_d;
            bus_data_q   <= bus_data_d;
            bus_dst_q    <= bus_dst_d;
            ptr_q        <= ptr_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    always_comb begin
        dst_valid = '0;
        dst_data  = '0;
        for (int j = 0; j < N_DST; j++) begin
            if (full && bus_dst_q == DW'(j)) begin
                dst_valid[j]                = 1'b1;
                dst_data[j*WIDTH +: WIDTH] = bus_data_q;
            end
        end
    end

    assign err_drop   = drop;
    assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_bus_xbar_arb.sv
// Self-checking bench for bus_xbar_arb: a 4x4 instance driven from a vector table
// with a delivery scoreboard, plus a 4x3 instance for out-of-range discards.
module tb_bus_xbar_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic [3:0]  src_valid, src_ready, dst_valid, dst_ready;
    logic [31:0] src_data, dst_data;
    logic [7:0]  src_dst;
    logic        err_drop;
    logic [15:0] xfer_count;

    logic [3:0]  sv3, srdy3;
    logic [31:0] sd3;
    logic [7:0]  sdst3;
    logic [2:0]  dv3, dr3;
    logic [23:0] dd3;
    logic        err3;
    logic [15:0] cnt3;

    bus_xbar_arb #(.WIDTH(8), .N_SRC(4), .N_DST(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .src_valid(src_valid), .src_data(src_data), .src_dst(src_dst),
        .src_ready(src_ready),
        .dst_valid(dst_valid), .dst_data(dst_data), .dst_ready(dst_ready),
        .err_drop(err_drop), .xfer_count(xfer_count)
    );

    bus_xbar_arb #(.WIDTH(8), .N_SRC(4), .N_DST(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .src_valid(sv3), .src_data(sd3), .src_dst(sdst3),
        .src_ready(srdy3),
        .dst_valid(dv3), .dst_data(dd3), .dst_ready(dr3),
        .err_drop(err3), .xfer_count(cnt3)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [1:0] dst;
        logic [7:0] data;
    } sb_t;

    sb_t sb_q[$];
    bit  sb_en = 1'b1;

    // Words leave the DUT at the edge following a negedge where valid & ready on a lane.
    always @(negedge clk) begin
        if (sb_en && rst_n) begin
            for (int j = 0; j < 4; j++) begin
                if (dst_valid[j] && dst_ready[j]) begin
                    if (sb_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL sb_unexpected: lane %0d data %h, expected none",
                                 j, dst_data[j*8 +: 8]);
                    end else begin
                        sb_t e;
                        e = sb_q.pop_front();
                        chk("sb_lane", 32'(j), 32'(e.dst));
                        chk("sb_data", 32'(dst_data[j*8 +: 8]), 32'(e.data));
                    end
                end
            end
        end
    end

    typedef struct {
        logic [3:0]  sv;
        logic [31:0] sd;
        logic [7:0]  sdst;
        logic [3:0]  dr;
        logic [3:0]  srdy;
        logic [3:0]  dvld;
        logic [31:0] ddata;
        logic [15:0] cnt;
    } vec_t;

    localparam int NV = 20;
    vec_t vt[NV];

    function automatic vec_t mk(input logic [3:0] sv, input logic [31:0] sd,
                                input logic [7:0] sdst, input logic [3:0] dr,
                                input logic [3:0] srdy, input logic [3:0] dvld,
                                input logic [31:0] ddata, input logic [15:0] cnt);
        vec_t v;
        v.sv = sv; v.sd = sd; v.sdst = sdst; v.dr = dr;
        v.srdy = srdy; v.dvld = dvld; v.ddata = ddata; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        logic [31:0] rr_a, rr_b, one_w, bp_w;
        rr_a  = 32'h13121110;
        rr_b  = 32'h13121120;
        one_w = 32'h00A50000;
        bp_w  = 32'h0000B1B0;
        // round robin from ptr=0: source i -> destination 3-i
        vt[0]  = mk(4'b1111, rr_a, 8'h1B, 4'hF, 4'b0001, 4'b0000, 32'h00000000, 16'd0);
        vt[1]  = mk(4'b1111, rr_b, 8'h1B, 4'hF, 4'b0010, 4'b1000, 32'h10000000, 16'd0);
        vt[2]  = mk(4'b1101, rr_b, 8'h1B, 4'hF, 4'b0100, 4'b0100, 32'h00110000, 16'd1);
        vt[3]  = mk(4'b1001, rr_b, 8'h1B, 4'hF, 4'b1000, 4'b0010, 32'h00001200, 16'd2);
        vt[4]  = mk(4'b0001, rr_b, 8'h1B, 4'hF, 4'b0001, 4'b0001, 32'h00000013, 16'd3);
        vt[5]  = mk(4'b0000, rr_b, 8'h1B, 4'hF, 4'b0000, 4'b1000, 32'h20000000, 16'd4);
        vt[6]  = mk(4'b0000, rr_b, 8'h1B, 4'hF, 4'b0000, 4'b0000, 32'h00000000, 16'd5);
        // single transfer src2 -> dst3 with a 3-cycle stall
        vt[7]  = mk(4'b0100, one_w, 8'h30, 4'h0, 4'b0100, 4'b0000, 32'h00000000, 16'd5);
        vt[8]  = mk(4'b0000, one_w, 8'h30, 4'h0, 4'b0000, 4'b1000, 32'hA5000000, 16'd5);
        vt[9]  = mk(4'b0000, one_w, 8'h30, 4'h0, 4'b0000, 4'b1000, 32'hA5000000, 16'd5);
        vt[10] = mk(4'b0000, one_w, 8'h30, 4'h0, 4'b0000, 4'b1000, 32'hA5000000, 16'd5);
        vt[11] = mk(4'b0000, one_w, 8'h30, 4'h8, 4'b0000, 4'b1000, 32'hA5000000, 16'd5);
        vt[12] = mk(4'b0000, one_w, 8'h30, 4'h0, 4'b0000, 4'b0000, 32'h00000000, 16'd6);
        // backpressure then back-to-back: src0 -> dst1, src1 -> dst2 waiting
        vt[13] = mk(4'b0011, bp_w, 8'h09, 4'h0, 4'b0001, 4'b0000, 32'h00000000, 16'd6);
        vt[14] = mk(4'b0010, bp_w, 8'h09, 4'hD, 4'b0000, 4'b0010, 32'h0000B000, 16'd6);
        vt[15] = mk(4'b0010, bp_w, 8'h09, 4'h0, 4'b0000, 4'b0010, 32'h0000B000, 16'd6);
        vt[16] = mk(4'b0010, bp_w, 8'h09, 4'h2, 4'b0010, 4'b0010, 32'h0000B000, 16'd6);
        vt[17] = mk(4'b0000, bp_w, 8'h09, 4'h2, 4'b0000, 4'b0100, 32'h00B10000, 16'd7);
        vt[18] = mk(4'b0000, bp_w, 8'h09, 4'h4, 4'b0000, 4'b0100, 32'h00B10000, 16'd7);
        vt[19] = mk(4'b0000, bp_w, 8'h09, 4'h0, 4'b0000, 4'b0000, 32'h00000000, 16'd8);

        src_valid = 4'b1111; src_data = '0; src_dst = '0; dst_ready = '0;
        sv3 = '0; sd3 = '0; sdst3 = '0; dr3 = '0;

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_src_ready", 32'(src_ready), 32'h0);
        chk("rst_dst_valid", 32'(dst_valid), 32'h0);
        chk("rst_dst_data", dst_data, 32'h0);
        chk("rst_xfer_count", 32'(xfer_count), 32'h0);
        chk("rst_err_drop", 32'(err_drop), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            src_valid = vt[i].sv;
            src_data  = vt[i].sd;
            src_dst   = vt[i].sdst;
            dst_ready = vt[i].dr;
            for (int g = 0; g < 4; g++) begin
                if (vt[i].srdy[g]) sb_q.push_back({vt[i].sdst[g*2 +: 2], vt[i].sd[g*8 +: 8]});
            end
            @(negedge clk);
            chk($sformatf("v%0d_src_ready", i), 32'(src_ready), 32'(vt[i].srdy));
            chk($sformatf("v%0d_dst_valid", i), 32'(dst_valid), 32'(vt[i].dvld));
            chk($sformatf("v%0d_dst_data", i), dst_data, vt[i].ddata);
            chk($sformatf("v%0d_xfer_count", i), 32'(xfer_count), 32'(vt[i].cnt));
            @(posedge clk); #1;
        end
        chk("sb_empty", 32'(sb_q.size()), 32'h0);

        // out-of-range discard on the 3-destination instance
        sv3 = 4'b0001; sd3 = 32'h0000005A; sdst3 = 8'h03; dr3 = 3'b111;
        @(negedge clk);
        chk("oor_accept", 32'(srdy3), 32'h1);
        chk("oor_err_pre", 32'(err3), 32'h0);
        @(posedge clk); #1;
        sv3 = 4'b0010; sd3 = 32'h0000665A; sdst3 = 8'h0B;
        @(negedge clk);
        chk("oor_err", 32'(err3), 32'h1);
        chk("oor_dst_valid", 32'(dv3), 32'h0);
        chk("oor_dst_data", 32'(dd3), 32'h0);
        chk("oor_count", 32'(cnt3), 32'h0);
        chk("oor_reaccept", 32'(srdy3), 32'h2);
        @(posedge clk); #1;
        sv3 = 4'b0000; dr3 = 3'b100;
        @(negedge clk);
        chk("oor_err_once", 32'(err3), 32'h0);
        chk("oor_next_valid", 32'(dv3), 32'h4);
        chk("oor_next_data", 32'(dd3), 32'h00660000);
        @(posedge clk); #1;
        @(negedge clk);
        chk("oor_next_count", 32'(cnt3), 32'h1);
        chk("oor_idle_valid", 32'(dv3), 32'h0);

        // counter wrap: stream one word per cycle from a clean reset
        sb_en = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("rst2_xfer_count", 32'(xfer_count), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        src_valid = 4'b1111; src_data = 32'h44332211; src_dst = 8'hE4; dst_ready = 4'hF;
        repeat (65536) @(posedge clk);
        @(negedge clk);
        chk("wrap_ffff", 32'(xfer_count), 32'h0000FFFF);
        @(posedge clk);
        @(negedge clk);
        chk("wrap_zero", 32'(xfer_count), 32'h0);

        // stall, then asynchronous reset between clock edges
        @(posedge clk); #1;
        dst_ready = 4'h0;
        @(negedge clk);
        chk("stall_dst_valid", 32'(|dst_valid), 32'h1);
        chk("stall_src_ready", 32'(src_ready), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_src_ready", 32'(src_ready), 32'h0);
        chk("arst_dst_valid", 32'(dst_valid), 32'h0);
        chk("arst_dst_data", dst_data, 32'h0);
        chk("arst_xfer_count", 32'(xfer_count), 32'h0);
        chk("arst_err_drop", 32'(err_drop), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("arst_release_ready", 32'(src_ready), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_xbar_arb.md
# bus_xbar_arb

Registered, parametrised shared-bus crossbar: any of N_SRC byte-lane sources can deliver a word to any of N_DST destinations over one shared holding register, with round-robin arbitration and valid/ready handshakes on both sides. It generalises the fixed two-source/two-destination BUS switch in the MEMORY group into a clocked transfer unit. It sits between register/memory producers and consumers in the datapath.

## Interface
- WIDTH, 8: data word width in bits.
- N_SRC, 4: number of sources, at least 2.
- N_DST, 4: number of destinations, at least 2.
- DW, $clog2(N_DST): destination index width (derived, not overridden).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- src_valid  in  N_SRC  per-source request.
- src_data  in  N_SRC*WIDTH  source i word at [i*WIDTH +: WIDTH].
- src_dst  in  N_SRC*DW  source i destination index at [i*DW +: DW].
- src_ready  out  N_SRC  one-hot or zero; accept strobe for the granted source.
- dst_valid  out  N_DST  one-hot or zero; word available at that destination.
- dst_data  out  N_DST*WIDTH  destination j word at [j*WIDTH +: WIDTH]; non-selected lanes are 0.
- dst_ready  in  N_DST  per-destination accept.
- err_drop  out  1  one-cycle pulse when an out-of-range destination word is discarded.
- xfer_count  out  16  completed deliveries, wraps at 2^16.

## Operation
- State is the holding register: `full`, `bus_data[WIDTH]`, `bus_dst[DW]`, plus round-robin pointer `ptr`, which ranges 0..N_SRC-1.
- FSM states:
  - EMPTY (full=0): register free.
  - FULL (full=1): a word is presented to destination `bus_dst`.
- Arbitration is combinational. Grant `g` is the first i with src_valid[i]=1, searching cyclically from ptr. No grant if no source is valid.
- `take = full & dst_ready[bus_dst]`.
- `free = ~full | take`.
- src_ready[g] = free & rst_n. All other src_ready bits are 0.
- Accept happens when src_valid[g] & src_ready[g]. On accept:
  - bus_data <= word of g.
  - bus_dst <= index of g.
  - full <= 1.
  - ptr <= (g+1) mod N_SRC.
- Take without accept: full <= 0.
- Take and accept in the same cycle: the register is refilled and full stays 1. This is the back-to-back case.
- dst_valid[bus_dst] = full when bus_dst < N_DST. dst_data lane bus_dst = bus_data. All other lanes and valids are 0.
- Out-of-range bus_dst (bus_dst >= N_DST, possible only when N_DST is not a power of 2):
  - On the cycle after the accept, the word is discarded: full <= 0, err_drop = 1 for that cycle.
  - xfer_count is unchanged.
  - A new accept is allowed in that same cycle.
- xfer_count increments by 1 on every take and wraps from 0xFFFF to 0x0000.
- src_data and src_dst are sampled only on accept. A source must hold valid, data and dst stable until accepted.
- Once dst_valid is asserted, it and dst_data stay stable until the take.

## Timing
- Reset (rst_n=0, asynchronous): full=0, ptr=0, xfer_count=0, bus_data=0, bus_dst=0. All src_ready, dst_valid, dst_data and err_drop are 0 while reset is held, independent of clk.
- Reset mid-transfer: the held word is lost and no delivery is counted. After rst_n deasserts, the first rising edge can accept.
- Latency: a word accepted at edge k is visible on dst_valid/dst_data from after edge k until the edge where dst_ready is seen high.
- Throughput: 1 word/cycle when the destinations keep dst_ready high. Back-to-back transfers insert no bubble.
- Backpressure: with dst_ready[bus_dst]=0 all src_ready stay 0. The stall is unbounded and the word is never dropped.
- dst_ready on non-target destinations is ignored.
- Fairness: a continuously valid source is granted within N_SRC accepts.
- err_drop is combinational from full and bus_dst, so it pulses for exactly one cycle per discarded word.

## Test plan
- Reset: hold rst_n=0 with src_valid=4'b1111 -> src_ready=0, dst_valid=0, dst_data=0, xfer_count=0. Release -> src_ready=4'b0001 on the first cycle.
- Single transfer: src 2 sends 0xA5 to dst 3, dst_ready=0 for 3 cycles then 1 -> src_ready[2] pulses once. dst_valid=4'b1000 with lane 3=0xA5 held for 4 cycles, all other lanes 0. xfer_count=1.
- Round-robin: all four sources valid continuously, dst_ready all 1 -> grant order 0,1,2,3,0 on consecutive cycles. Words arrive one per cycle. xfer_count=5 after 5 deliveries.
- Backpressure plus back-to-back: src 0 sends to dst 1, dst_ready[1] low 2 cycles, src 1 waiting -> src_ready[1] rises on the same cycle dst_ready[1] goes high. The next word is presented on the following cycle with no empty gap.
- Out-of-range (N_DST=3): src 0 sends to dst index 3 -> err_drop=1 for one cycle, all dst_valid=0, xfer_count unchanged.
- Wrap and async reset: preload 0xFFFF deliveries then one more -> xfer_count=0x0000. Assert rst_n mid-stall -> outputs clear immediately, with no clk edge required.
